// File: rtl/ps2_host_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_pkg
// Shared keyboard-port definitions: PS/2 command and reply byte values, the
// host transmitter state encoding and small frame-building helpers.
// ---------------------------------------------------------------------------
package ps2_host_tx_pkg;

   // Host-to-keyboard command bytes
   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

   // Keyboard-to-host reply bytes
   localparam logic [7:0] PS2_ACK          = 8'hFA;
   localparam logic [7:0] PS2_RESEND       = 8'hFE;

   // Fall count at which the stop bit is on the wire; the next fall is the ACK
   localparam logic [3:0] PS2_STOP_FALL    = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_IDLE = 3'd4,
      ST_DONE      = 3'd5
   } ps2_tx_state_e;

   // Odd parity: the parity bit makes the total count of ones odd
   function automatic logic ps2_odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   // Wire order from bit 0 upward: start, d0..d7, parity, stop
   function automatic logic [10:0] ps2_build_frame(input logic [7:0] data);
      return {1'b1, ps2_odd_parity(data), data, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Brings the asynchronous PS/2 clock and data pin levels into the clk domain
// through two flops each, and flags a falling edge of the synchronised clock.
// Shared by the host transmitter and the scan-code receiver.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   ps2_clk_i   - raw PS/2 clock pin level
//   ps2_dat_i   - raw PS/2 data pin level
//   clk_sync    - synchronised clock level
//   dat_sync    - synchronised data level
//   clk_fall    - one-cycle flag: clk_sync was 1 last cycle and is 0 now
// ---------------------------------------------------------------------------
module ps2_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_sync,
   output logic dat_sync,
   output logic clk_fall
);

   logic clk_meta_r;
   logic clk_sync_r;
   logic clk_prev_r;
   logic dat_meta_r;
   logic dat_sync_r;

   // Synchroniser chains; reset to the idle (released, high) line level
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_r <= 1'b1;
         clk_sync_r <= 1'b1;
         clk_prev_r <= 1'b1;
         dat_meta_r <= 1'b1;
         dat_sync_r <= 1'b1;
      end else begin
         clk_meta_r <= ps2_clk_i;
         clk_sync_r <= clk_meta_r;
         clk_prev_r <= clk_sync_r;
         dat_meta_r <= ps2_dat_i;
         dat_sync_r <= dat_meta_r;
      end
   end

   assign clk_sync = clk_sync_r;
   assign dat_sync = dat_sync_r;
   assign clk_fall = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request to
// send, then shifts one byte (start, 8 data LSB first, odd parity, stop) out
// on the device-generated clock and checks the device ACK bit. The line
// drivers are open-drain enables: 1 pulls the line low, 0 releases it.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   ps2_clk_i    - raw PS/2 clock pin level
//   ps2_dat_i    - raw PS/2 data pin level
//   ps2_clk_oe   - pull PS/2 clock low
//   ps2_dat_oe   - pull PS/2 data low
//   tx_data      - byte to send, captured on an accepted tx_write
//   tx_write     - single-cycle send request (ignored while busy or done)
//   tx_busy      - transaction in progress
//   tx_done      - one-cycle end-of-transaction pulse
//   tx_error     - with tx_done: NACK received or frame timed out
// ---------------------------------------------------------------------------
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLK_HZ         = 14_000_000,
   parameter int INHIBIT_CYCLES = CLK_HZ / 10000,
   parameter int TIMEOUT_CYCLES = CLK_HZ / 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_write,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic clk_sync_s;
   logic dat_sync_s;
   logic clk_fall_s;

   ps2_tx_state_e    state_r,   state_s;
   logic [10:0]      frame_r,   frame_s;
   logic [3:0]       n_r,       n_s;
   logic [INH_W-1:0] inh_cnt_r, inh_cnt_s;
   logic [TO_W-1:0]  to_cnt_r,  to_cnt_s;
   logic             err_r,     err_s;

   logic clk_oe_s;
   logic dat_oe_s;
   logic busy_s;
   logic done_s;
   logic error_s;

   ps2_line_sync u_line_sync (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk_i (ps2_clk_i),
      .ps2_dat_i (ps2_dat_i),
      .clk_sync  (clk_sync_s),
      .dat_sync  (dat_sync_s),
      .clk_fall  (clk_fall_s)
   );

   // Next-state, datapath and next-output logic
   always_comb begin
      state_s   = state_r;
      frame_s   = frame_r;
      n_s       = n_r;
      inh_cnt_s = inh_cnt_r;
      to_cnt_s  = to_cnt_r;
      err_s     = err_r;

      case (state_r)
         ST_IDLE: begin
            if (tx_write) begin
               state_s   = ST_INHIBIT;
               frame_s   = ps2_build_frame(tx_data);
               n_s       = 4'd0;
               inh_cnt_s = '0;
               to_cnt_s  = '0;
               err_s     = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_INHIBIT: begin
            if (inh_cnt_r == INH_LAST) begin
               state_s = ST_REQ;
            end else begin
               inh_cnt_s = inh_cnt_r + INH_W'(1'b1);
            end
         end

         // Data already pulled low here: this cycle presents the start bit
         ST_REQ: begin
            state_s  = ST_SEND;
            to_cnt_s = '0;
         end

         // Each detected fall advances the frame; the stop bit is left on
         // the wire until the next fall, where the device ACK is sampled.
         ST_SEND: begin
            to_cnt_s = to_cnt_r + TO_W'(1'b1);
            if (to_cnt_r == TO_LAST) begin
               state_s = ST_DONE;
               err_s   = 1'b1;
            end else if (clk_fall_s) begin
               n_s = n_r + 4'd1;
               if (n_r == PS2_STOP_FALL) begin
                  err_s   = dat_sync_s;
                  state_s = ST_WAIT_IDLE;
               end else begin
                  frame_s = {1'b1, frame_r[10:1]};
               end
            end else begin
               n_s = n_r;
            end
         end

         ST_WAIT_IDLE: begin
            to_cnt_s = to_cnt_r + TO_W'(1'b1);
            if (to_cnt_r == TO_LAST) begin
               state_s = ST_DONE;
               err_s   = 1'b1;
            end else if (clk_sync_s && dat_sync_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT_IDLE;
            end
         end

         ST_DONE: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the next state
      clk_oe_s = (state_s == ST_INHIBIT) || (state_s == ST_REQ);
      dat_oe_s = (state_s == ST_REQ) || ((state_s == ST_SEND) && !frame_s[0]);
      busy_s   = (state_s == ST_INHIBIT) || (state_s == ST_REQ) ||
                 (state_s == ST_SEND) || (state_s == ST_WAIT_IDLE);
      done_s   = (state_s == ST_DONE);
      error_s  = (state_s == ST_DONE) && err_s;
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         frame_r    <= 11'h7FF;
         n_r        <= 4'd0;
         inh_cnt_r  <= '0;
         to_cnt_r   <= '0;
         err_r      <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_error   <= 1'b0;
      end else begin
         state_r    <= state_s;
         frame_r    <= frame_s;
         n_r        <= n_s;
         inh_cnt_r  <= inh_cnt_s;
         to_cnt_r   <= to_cnt_s;
         err_r      <= err_s;
         ps2_clk_oe <= clk_oe_s;
         ps2_dat_oe <= dat_oe_s;
         tx_busy    <= busy_s;
         tx_done    <= done_s;
         tx_error   <= error_s;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard model
// on open-drain lines and a frame reference computed from the byte value.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int CLK_HZ  = 14_000_000;
   localparam int INH     = CLK_HZ / 10000;
   localparam int TO      = 16000;

   logic       clk = 1'b0;
   logic       reset;
   logic       dev_clk;
   logic       dev_dat;
   logic       ps2_clk_i;
   logic       ps2_dat_i;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic [7:0] tx_data;
   logic       tx_write;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int frame_cnt = 0;
   int orphan_err = 0;
   logic       done_err = 1'b0;
   logic       done_busy = 1'b0;
   logic [1:0] done_oe = 2'b00;
   logic       clk_oe_prev = 1'b0;

   logic [10:0] dev_bits;
   bit          dev_ok;
   bit          frame_seen;

   // Open-drain wired-AND of host and device drivers
   assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(
      .CLK_HZ         (CLK_HZ),
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .tx_data    (tx_data),
      .tx_write   (tx_write),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder: done pulses, frames started, stray error pulses
   always @(negedge clk) begin
      clk_oe_prev <= ps2_clk_oe;
      if (ps2_clk_oe === 1'b1 && clk_oe_prev !== 1'b1) frame_cnt <= frame_cnt + 1;
      if (tx_done === 1'b1) begin
         done_cnt  <= done_cnt + 1;
         done_cyc  <= cyc;
         done_err  <= tx_error;
         done_busy <= tx_busy;
         done_oe   <= {ps2_clk_oe, ps2_dat_oe};
      end
      if (tx_error === 1'b1 && tx_done !== 1'b1) orphan_err <= orphan_err + 1;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1);
   end

   // Reference frame: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] exp_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = d[i];
         if (d[i]) ones = ones + 1;
      end
      f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send_byte(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_write = 1'b1;
      @(negedge clk);
      tx_write = 1'b0;
   endtask

   // Keyboard model: waits for request-to-send, then clocks nfalls falls,
   // sampling on each rising edge and answering with ack_bit after the stop bit
   task automatic dev_frame(input int half, input logic ack_bit, input int nfalls);
      int g;
      dev_bits = 11'h000;
      dev_ok   = 1'b1;
      g = 0;
      while (ps2_clk_oe !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
      g = 0;
      while (ps2_clk_oe !== 1'b0 && g < 5000) begin @(negedge clk); g++; end
      if (ps2_clk_oe !== 1'b0) begin
         dev_ok = 1'b0;
      end else begin
         repeat (half) @(negedge clk);
         dev_bits[0] = ps2_dat_i;
         for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) dev_bits[k] = ps2_dat_i;
            if (k == 10) begin
               repeat (half / 2) @(negedge clk);
               dev_dat = ack_bit;
               repeat (half - half / 2) @(negedge clk);
            end else if (k == 11) begin
               dev_dat = 1'b1;
               repeat (half) @(negedge clk);
            end else begin
               repeat (half) @(negedge clk);
            end
         end
      end
   endtask

   task automatic do_frame(input logic [7:0] d, input int half, input logic ack_bit);
      int prev;
      int g;
      prev = done_cnt;
      fork
         send_byte(d);
         dev_frame(half, ack_bit, 11);
      join
      g = 0;
      while (done_cnt == prev && g < 300) begin @(negedge clk); g++; end
      frame_seen = (done_cnt == prev + 1);
   endtask

   task automatic test_reset();
      reset = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1;
      tx_write = 1'b0; tx_data = 8'h00;
      repeat (4) @(negedge clk);
      checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b required 0", ps2_clk_oe); else passes++;
      checks++; if (ps2_dat_oe !== 1'b0) $display("FAIL reset_dat_oe: got %b required 0", ps2_dat_oe); else passes++;
      checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", tx_busy); else passes++;
      checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b required 0", tx_done); else passes++;
      checks++; if (tx_error !== 1'b0) $display("FAIL reset_error: got %b required 0", tx_error); else passes++;
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_send_ed();
      do_frame(PS2_CMD_SET_LEDS, 560, 1'b0);
      checks++; if (!dev_ok) $display("FAIL ed_handshake: got no clock release required release"); else passes++;
      checks++; if (dev_bits !== exp_frame(PS2_CMD_SET_LEDS)) $display("FAIL ed_bits: got %b required %b", dev_bits, exp_frame(PS2_CMD_SET_LEDS)); else passes++;
      checks++; if (!frame_seen) $display("FAIL ed_done: got %0d done pulses required 1", done_cnt); else passes++;
      checks++; if (done_err !== 1'b0) $display("FAIL ed_error: got %b required 0", done_err); else passes++;
      checks++; if (done_busy !== 1'b0) $display("FAIL ed_busy_at_done: got %b required 0", done_busy); else passes++;
   endtask

   task automatic test_send_07();
      int inh;
      int prev;
      int g;
      prev = done_cnt;
      fork
         begin
            @(negedge clk);
            tx_data  = 8'h07;
            tx_write = 1'b1;
            @(negedge clk);
            tx_write = 1'b0;
            checks++; if (tx_busy !== 1'b1 || ps2_clk_oe !== 1'b1) $display("FAIL accept_timing: got busy=%b clk_oe=%b required 1 1", tx_busy, ps2_clk_oe); else passes++;
            inh = 0;
            while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && inh < 3000) begin inh++; @(negedge clk); end
            checks++; if (inh != INH) $display("FAIL inhibit_len: got %0d required %0d", inh, INH); else passes++;
            checks++; if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b1) $display("FAIL req_cycle: got clk_oe=%b dat_oe=%b required 1 1", ps2_clk_oe, ps2_dat_oe); else passes++;
            @(negedge clk);
            checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) $display("FAIL send_entry: got clk_oe=%b dat_oe=%b required 0 1", ps2_clk_oe, ps2_dat_oe); else passes++;
         end
         dev_frame(100, 1'b0, 11);
      join
      g = 0;
      while (done_cnt == prev && g < 300) begin @(negedge clk); g++; end
      checks++; if (dev_bits[9] !== 1'b0) $display("FAIL p07_parity: got %b required 0", dev_bits[9]); else passes++;
      checks++; if (dev_bits !== exp_frame(8'h07)) $display("FAIL p07_bits: got %b required %b", dev_bits, exp_frame(8'h07)); else passes++;
      checks++; if (done_cnt != prev + 1 || done_err !== 1'b0) $display("FAIL p07_done: got %0d pulses err=%b required 1 pulse err=0", done_cnt - prev, done_err); else passes++;
   endtask

   task automatic test_nack();
      do_frame(PS2_CMD_RESET, 100, 1'b1);
      checks++; if (dev_bits !== exp_frame(PS2_CMD_RESET)) $display("FAIL nack_bits: got %b required %b", dev_bits, exp_frame(PS2_CMD_RESET)); else passes++;
      checks++; if (!frame_seen || done_err !== 1'b1) $display("FAIL nack_pulse: got seen=%b err=%b required 1 1", frame_seen, done_err); else passes++;
      repeat (3) @(negedge clk);
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) $display("FAIL nack_release: got clk_oe=%b dat_oe=%b required 0 0", ps2_clk_oe, ps2_dat_oe); else passes++;
   endtask

   task automatic test_timeout();
      int prev;
      int g;
      int s;
      prev = done_cnt;
      send_byte(8'h5A);
      g = 0;
      while (ps2_clk_oe !== 1'b0 && g < 5000) begin @(negedge clk); g++; end
      s = cyc;
      g = 0;
      while (done_cnt == prev && g < TO + 200) begin @(negedge clk); g++; end
      checks++; if (done_cnt != prev + 1) $display("FAIL timeout_done: got %0d pulses required 1", done_cnt - prev); else passes++;
      checks++; if (done_cyc - s != TO) $display("FAIL timeout_latency: got %0d required %0d", done_cyc - s, TO); else passes++;
      checks++; if (done_err !== 1'b1) $display("FAIL timeout_error: got %b required 1", done_err); else passes++;
      checks++; if (done_oe !== 2'b00) $display("FAIL timeout_release: got %b required 00", done_oe); else passes++;
   endtask

   task automatic test_busy_ignore();
      int pf;
      int pd;
      int g;
      pf = frame_cnt;
      pd = done_cnt;
      fork
         send_byte(8'h3C);
         dev_frame(80, 1'b0, 11);
         begin
            repeat (300) @(negedge clk);
            tx_data  = 8'h99;
            tx_write = 1'b1;
            @(negedge clk);
            tx_write = 1'b0;
            g = 0;
            while (tx_done !== 1'b1 && g < 20000) begin @(negedge clk); g++; end
            tx_data  = 8'h11;
            tx_write = 1'b1;
            @(negedge clk);
            tx_write = 1'b0;
         end
      join
      repeat (50) @(negedge clk);
      checks++; if (dev_bits !== exp_frame(8'h3C)) $display("FAIL busy_bits: got %b required %b", dev_bits, exp_frame(8'h3C)); else passes++;
      checks++; if (frame_cnt != pf + 1) $display("FAIL busy_frames: got %0d required 1", frame_cnt - pf); else passes++;
      checks++; if (done_cnt != pd + 1) $display("FAIL busy_dones: got %0d required 1", done_cnt - pd); else passes++;
      checks++; if (tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0) $display("FAIL busy_after: got busy=%b clk_oe=%b required 0 0", tx_busy, ps2_clk_oe); else passes++;
   endtask

   task automatic test_reset_midframe();
      int prev;
      prev = done_cnt;
      fork
         send_byte(8'h55);
         dev_frame(100, 1'b0, 5);
      join
      checks++; if (tx_busy !== 1'b1) $display("FAIL midframe_busy: got %b required 1", tx_busy); else passes++;
      reset = 1'b1;
      @(negedge clk);
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_busy !== 1'b0) $display("FAIL midframe_reset: got clk_oe=%b dat_oe=%b busy=%b required 0 0 0", ps2_clk_oe, ps2_dat_oe, tx_busy); else passes++;
      reset = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (done_cnt != prev) $display("FAIL midframe_nodone: got %0d pulses required 0", done_cnt - prev); else passes++;
      do_frame(8'hF4, 100, 1'b0);
      checks++; if (dev_bits !== exp_frame(8'hF4) || !frame_seen || done_err !== 1'b0) $display("FAIL after_reset_f4: got bits=%b seen=%b err=%b required %b 1 0", dev_bits, frame_seen, done_err, exp_frame(8'hF4)); else passes++;
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       ack;
      int         half;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       d = PS2_CMD_ECHO;
            1:       d = PS2_ACK;
            2:       d = PS2_RESEND;
            default: d = 8'($urandom_range(0, 255));
         endcase
         ack  = 1'($urandom_range(0, 1));
         half = $urandom_range(60, 150);
         dev_clk = 1'b0;
         repeat (3) @(negedge clk);
         dev_clk = 1'b1;
         repeat (10) @(negedge clk);
         checks++; if (tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0) $display("FAIL idle_glitch: got busy=%b clk_oe=%b required 0 0", tx_busy, ps2_clk_oe); else passes++;
         do_frame(d, half, ack);
         checks++; if (dev_bits !== exp_frame(d)) $display("FAIL rand_bits: byte %h got %b required %b", d, dev_bits, exp_frame(d)); else passes++;
         checks++; if (!frame_seen || done_err !== ack) $display("FAIL rand_result: byte %h got seen=%b err=%b required 1 %b", d, frame_seen, done_err, ack); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_send_07();
      test_nack();
      test_timeout();
      test_busy_ignore();
      test_reset_midframe();
      test_random();
      checks++; if (orphan_err != 0) $display("FAIL error_without_done: got %0d required 0", orphan_err); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
